// File: rtl/opad_share_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one output pad.
// An accepted word goes out as a frame: a start bit (0), the data LSB-first, then a stop bit (1).
module opad_share_arbiter #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1,
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    outpad,
  output logic                    busy,
  output logic [IDW-1:0]          grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic               outpad_q, outpad_d;
  logic               busy_q, busy_d;

  logic               found;
  logic               accept;
  logic [IDW-1:0]     sel;
  logic [IDW-1:0]     idx;
  logic [IDW-1:0]     sel_next;
  logic [WIDTH-1:0]   word;
  logic               cyc_last;
  logic               bit_last;

  // Search starts at ptr and wraps, so the most recently served requester goes last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (sel == IDW'(k)) word = req_data[k*WIDTH +: WIDTH];
    end
  end

  // valid/ready: a word transfers in any cycle where both the valid and ready bits of a requester are high.
  assign accept    = (state_q == S_IDLE) && found && !rst;
  assign req_ready = accept ? (NREQ'(1) << sel) : '0;
  assign sel_next  = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
  assign cyc_last  = (cyc_q == CW'(BIT_CYCLES - 1));
  assign bit_last  = (bit_q == BW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    outpad_d = outpad_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        outpad_d = 1'b1;
        busy_d   = 1'b0;
        if (accept) begin
          state_d  = S_START;
          shreg_d  = word;
          gid_d    = sel;
          ptr_d    = sel_next;
          cyc_d    = '0;
          bit_d    = '0;
          outpad_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        if (cyc_last) begin
          state_d  = S_DATA;
          cyc_d    = '0;
          bit_d    = '0;
          outpad_d = shreg_q[0];
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d = '0;
          if (bit_last) begin
            state_d  = S_STOP;
            outpad_d = 1'b1;
          end else begin
            bit_d    = bit_q + BW'(1);
            shreg_d  = shreg_q >> 1;
            outpad_d = shreg_d[0];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        outpad_d = 1'b1;
        if (cyc_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        outpad_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      ptr_q    <= '0;
      gid_q    <= '0;
      outpad_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      outpad_q <= outpad_d;
      busy_q   <= busy_d;
    end
  end

  assign outpad   = outpad_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_opad_share_arbiter.sv
// Bench for opad_share_arbiter: a main 4x8-bit, 2-cycle-per-bit instance, a 1-cycle-per-bit
// instance and a single-requester instance, checked against hand-computed frames.
module tb_opad_share_arbiter;

  localparam int B = 2;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // main instance
  logic [3:0]  m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_ready;
  logic        m_outpad, m_busy;
  logic [1:0]  m_gid;
  // one cycle per bit
  logic [3:0]  b_valid;
  logic [31:0] b_data;
  logic [3:0]  b_ready;
  logic        b_outpad, b_busy;
  logic [1:0]  b_gid;
  // single requester
  logic [0:0]  n_valid;
  logic [7:0]  n_data;
  logic [0:0]  n_ready;
  logic        n_outpad, n_busy;
  logic [0:0]  n_gid;

  opad_share_arbiter #(.NREQ(4), .WIDTH(W), .BIT_CYCLES(B)) u_main (
    .clk(clk), .rst(rst), .req_valid(m_valid), .req_data(m_data), .req_ready(m_ready),
    .outpad(m_outpad), .busy(m_busy), .grant_id(m_gid));

  opad_share_arbiter #(.NREQ(4), .WIDTH(8), .BIT_CYCLES(1)) u_b1 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .outpad(b_outpad), .busy(b_busy), .grant_id(b_gid));

  opad_share_arbiter #(.NREQ(1), .WIDTH(8), .BIT_CYCLES(2)) u_n1 (
    .clk(clk), .rst(rst), .req_valid(n_valid), .req_data(n_data), .req_ready(n_ready),
    .outpad(n_outpad), .busy(n_busy), .grant_id(n_gid));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word on the main instance must reappear as a frame on its pad.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cap;
  logic [W-1:0] w_acc;
  logic [W-1:0] w_exp;
  bit           mon_on  = 1'b0;
  int           mon_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
      exp_q.delete();
    end else begin
      if (mon_on) begin
        mon_cnt++;
        if (mon_cnt <= B) begin
          chk("mon_start_bit", 32'(m_outpad), 32'd0);
        end else if (mon_cnt <= (W + 1) * B) begin
          cap[(mon_cnt - 1) / B - 1] = m_outpad;
        end else begin
          chk("mon_stop_bit", 32'(m_outpad), 32'd1);
          if (mon_cnt == (W + 2) * B) begin
            mon_on = 1'b0;
            if (exp_q.size() == 0) begin
              chk("mon_queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
              w_exp = exp_q.pop_front();
              chk("mon_frame_word", 32'(cap), 32'(w_exp));
            end
          end
        end
      end
      if (m_ready != 4'b0) begin
        if (mon_on) chk("mon_accept_while_busy", 32'(mon_on), 32'd0);
        w_acc = '0;
        for (int i = 0; i < 4; i++) if (m_ready[i]) w_acc = m_data[i*8 +: 8];
        exp_q.push_back(w_acc);
        mon_on  = 1'b1;
        mon_cnt = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic wait_accept(input logic [3:0] exp_ready, output int t);
    bit got;
    got = 1'b0;
    t   = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (m_ready != 4'b0) begin
        got = 1'b1;
        t   = cyc_cnt;
        chk("accept_onehot", 32'(m_ready), 32'(exp_ready));
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no req_ready expected %b", exp_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic       exp_outpad;
    logic       exp_busy;
    logic [1:0] exp_gid;
    logic       chk_gid;
  } vec_t;

  vec_t        vecs[22];
  logic [0:19] pat;
  int          t0, t1, tprev;
  logic [3:0]  order_oh;
  logic [7:0]  nword;
  int          k;

  initial begin
    // single-word frame for req 2 = 0xA5, rows are cycles T..T+21
    pat = 20'b00110011000011001111;
    vecs[0] = '{valid: 4'b0100, exp_ready: 4'b0100, exp_outpad: 1'b1, exp_busy: 1'b0,
                exp_gid: 2'd0, chk_gid: 1'b1};
    for (int i = 1; i <= 20; i++)
      vecs[i] = '{valid: 4'b0000, exp_ready: 4'b0000, exp_outpad: pat[i-1], exp_busy: 1'b1,
                  exp_gid: 2'd2, chk_gid: 1'b1};
    vecs[21] = '{valid: 4'b0000, exp_ready: 4'b0000, exp_outpad: 1'b1, exp_busy: 1'b0,
                 exp_gid: 2'd2, chk_gid: 1'b0};

    // reset with every requester valid: nothing may be granted
    rst = 1'b1;
    m_valid = 4'hF; m_data = '0;
    b_valid = 4'hF; b_data = '0;
    n_valid = 1'b1; n_data = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", 32'(m_ready), 32'd0);
    chk("rst_outpad", 32'(m_outpad), 32'd1);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_gid", 32'(m_gid), 32'd0);
    chk("rst_b1_ready", 32'(b_ready), 32'd0);
    chk("rst_n1_ready", 32'(n_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = '0; b_valid = '0; n_valid = '0;

    // table-driven single frame
    m_data = 32'h00A5_0000;
    for (int i = 0; i < 22; i++) begin
      m_valid = vecs[i].valid;
      @(negedge clk);
      chk($sformatf("t1_ready[%0d]", i), 32'(m_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("t1_outpad[%0d]", i), 32'(m_outpad), 32'(vecs[i].exp_outpad));
      chk($sformatf("t1_busy[%0d]", i), 32'(m_busy), 32'(vecs[i].exp_busy));
      if (vecs[i].chk_gid) chk($sformatf("t1_gid[%0d]", i), 32'(m_gid), 32'(vecs[i].exp_gid));
      @(posedge clk); #1;
    end

    // all four continuously valid: 0,1,2,3,0 spaced 21 cycles
    do_reset();
    m_data  = 32'h4433_2211;
    m_valid = 4'hF;
    tprev = 0;
    for (int n = 0; n < 5; n++) begin
      order_oh = 4'b0001 << (n % 4);
      wait_accept(order_oh, t0);
      if (n > 0) chk($sformatf("rr_spacing[%0d]", n), 32'(t0 - tprev), 32'd21);
      tprev = t0;
      @(negedge clk);
      chk($sformatf("rr_gid[%0d]", n), 32'(m_gid), 32'(n % 4));
      chk($sformatf("rr_busy[%0d]", n), 32'(m_busy), 32'd1);
      @(posedge clk); #1;
    end
    m_valid = '0;
    repeat (22) @(posedge clk);
    #1;

    // pointer wrap: grant 3 (ptr=0), then {0,2} -> 0 then 2, then {0,1} with ptr=3 -> 0
    do_reset();
    m_valid = 4'b1000;
    wait_accept(4'b1000, t0);
    m_valid = 4'b0101;
    wait_accept(4'b0001, t0);
    m_valid = 4'b0100;
    wait_accept(4'b0100, t0);
    m_valid = 4'b0011;
    wait_accept(4'b0001, t0);
    m_valid = '0;
    repeat (22) @(posedge clk);
    #1;

    // reset during data bit 3 of a frame from req 1 (which leaves ptr=2)
    do_reset();
    m_valid = 4'b0010;
    wait_accept(4'b0010, t0);
    m_valid = '0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    m_valid = 4'b1010;
    @(negedge clk);
    chk("mid_rst_ready", 32'(m_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = '0;
    @(negedge clk);
    chk("post_rst_outpad", 32'(m_outpad), 32'd1);
    chk("post_rst_busy", 32'(m_busy), 32'd0);
    chk("post_rst_gid", 32'(m_gid), 32'd0);
    chk("post_rst_ready", 32'(m_ready), 32'd0);
    @(posedge clk); #1;
    m_valid = 4'b1010;
    wait_accept(4'b0010, t0);
    m_valid = '0;
    repeat (22) @(posedge clk);
    #1;

    // idle for 50 cycles
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("idle[%0d]", i), {m_ready, m_outpad, m_busy}, {4'b0000, 1'b1, 1'b0});
      @(posedge clk); #1;
    end

    // BIT_CYCLES=1, req 0 holds 0xFF: 11-cycle period
    b_data  = 32'h0000_00FF;
    b_valid = 4'b0001;
    k = 0;
    for (int i = 0; i < 20 && k == 0; i++) begin
      @(negedge clk);
      if (b_ready != 4'b0) k = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("b1_first_accept", 32'(k), 32'd1);
    for (int o = 0; o < 22; o++) begin
      if (o > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      chk($sformatf("b1_ready[%0d]", o), 32'(b_ready), (o % 11 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b1_outpad[%0d]", o), 32'(b_outpad), (o % 11 == 1) ? 32'd0 : 32'd1);
      chk($sformatf("b1_busy[%0d]", o), 32'(b_busy), (o % 11 == 0) ? 32'd0 : 32'd1);
    end
    @(posedge clk); #1;
    b_valid = '0;

    // NREQ=1: two back-to-back frames 0x3C then 0xC5
    n_valid = 1'b1;
    n_data  = 8'h3C;
    tprev   = 0;
    for (int f = 0; f < 2; f++) begin
      k = 0;
      for (int i = 0; i < 40 && k == 0; i++) begin
        @(negedge clk);
        if (n_ready == 1'b1) begin
          k = 1;
          t1 = cyc_cnt;
        end
        @(posedge clk); #1;
      end
      chk($sformatf("n1_accept[%0d]", f), 32'(k), 32'd1);
      if (f == 1) chk("n1_spacing", 32'(t1 - tprev), 32'd21);
      tprev  = t1;
      nword  = n_data;
      n_data = 8'hC5;
      for (int o = 1; o <= 20; o++) begin
        @(negedge clk);
        if (o <= 2)       chk($sformatf("n1_start[%0d]", f), 32'(n_outpad), 32'd0);
        else if (o <= 18) chk($sformatf("n1_bit[%0d,%0d]", f, o), 32'(n_outpad),
                              32'(nword[(o - 1) / 2 - 1]));
        else              chk($sformatf("n1_stop[%0d]", f), 32'(n_outpad), 32'd1);
        if (o == 1) begin
          chk($sformatf("n1_busy[%0d]", f), 32'(n_busy), 32'd1);
          chk($sformatf("n1_gid[%0d]", f), 32'(n_gid), 32'd0);
        end
        @(posedge clk); #1;
      end
    end
    n_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
